// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(12,8) encode / serial transmit path.
package hamming_pkg;

  localparam int CW_W   = 12;
  localparam int DATA_W = 8;

  // Parity bit positions inside the 12-bit codeword (1-based positions 1, 2, 4, 8).
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P4 = 3;
  localparam int P8 = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/hamming_encoder.sv
// Combinational Hamming(12,8) encoder.
// Codeword layout (MSB..LSB): {d7,d6,d5,d4,p8,d3,d2,d1,p4,d0,p2,p1}.
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   codeword
);

  // Place data bits at the non-power-of-two positions and fill in the check bits.
  always_comb begin
    codeword     = '0;
    codeword[P1] = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6];
    codeword[P2] = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6];
    codeword[2]  = data[0];
    codeword[P4] = data[1] ^ data[2] ^ data[3] ^ data[7];
    codeword[4]  = data[1];
    codeword[5]  = data[2];
    codeword[6]  = data[3];
    codeword[P8] = data[4] ^ data[5] ^ data[6] ^ data[7];
    codeword[8]  = data[4];
    codeword[9]  = data[5];
    codeword[10] = data[6];
    codeword[11] = data[7];
  end

endmodule

// File: rtl/hamming_serial_tx.sv
// Byte-in, serial-out Hamming(12,8) transmitter.
// Frame on tx: start(0), codeword bits 0..11 LSB first, [overall parity], stop(1).
// Each bit is held CLKS_PER_BIT clocks. Optional feature macro:
//   HAMMING_TX_PARITY_EN - insert an even overall-parity bit before the stop bit.
module hamming_serial_tx
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BIT = 4'(CW_W - 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [CW_W-1:0]   shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
`ifdef HAMMING_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [CW_W-1:0]   codeword;
  logic              accept;
  logic              bit_end;

  hamming_encoder u_enc (
    .data     (in_data),
    .codeword (codeword)
  );

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign bit_end  = (cnt_q == CNT_MAX);
  assign tx       = tx_q;
  assign busy     = busy_q;

  // Next-state, counter, shift-register and output-level logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef HAMMING_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d   = START;
          shreg_d   = codeword;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef HAMMING_TX_PARITY_EN
          parity_d  = ^codeword;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef HAMMING_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef HAMMING_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset aborts any frame at once and parks the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef HAMMING_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef HAMMING_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Directed bench for hamming_serial_tx at CLKS_PER_BIT = 4.
module tb_hamming_serial_tx;

  localparam int CPB = 4;
`ifdef HAMMING_TX_PARITY_EN
  localparam int NBITS = 15;
`else
  localparam int NBITS = 14;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic tx_log   [0:511];
  logic busy_log [0:511];
  logic rdy_log  [0:511];

  hamming_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Expected line level for frame bit period b of codeword cw with parity bit par.
  function automatic logic exp_bit(input logic [11:0] cw, input logic par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 12) return cw[b-1];
    if (NBITS == 15 && b == 13) return par;
    return 1'b1;
  endfunction

  // Record n negedge samples; optionally keep in_valid high with new data, or pulse in_valid.
  task automatic capture(input int n, input bit hold, input logic [7:0] next_data,
                         input int pulse_at, input logic [7:0] pulse_data);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = tx;
      busy_log[i] = busy;
      rdy_log[i]  = in_ready;
      if (i == 0) begin
        if (hold) in_data = next_data;
        else      in_valid = 1'b0;
      end
      if (i == pulse_at) begin
        in_valid = 1'b1;
        in_data  = pulse_data;
      end else if (pulse_at >= 0 && i == pulse_at + 1) begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, in_ready} !== 3'b101) begin
        errors++;
        $display("FAIL idle cycle %0d got tx/busy/rdy %b want 101", i, {tx, busy, in_ready});
      end
    end
  endtask

  task automatic test_frame_a5();
    int nb;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL a5_ready got %b want 1", in_ready); end
    in_data = 8'hA5; in_valid = 1'b1;
    capture(FLEN + 1, 1'b0, 8'h00, -1, 8'h00);
    nb = 0;
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (tx_log[i] !== exp_bit(12'hA27, 1'b0, i / CPB)) begin
        errors++;
        $display("FAIL a5_tx cycle %0d got %b want %b", i, tx_log[i], exp_bit(12'hA27, 1'b0, i / CPB));
      end
    end
    for (int i = 0; i <= FLEN; i++) nb += int'(busy_log[i]);
    checks++; if (nb != FLEN) begin errors++; $display("FAIL a5_busy_len got %0d want %0d", nb, FLEN); end
    checks++;
    if ({tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]} !== 3'b101) begin
      errors++;
      $display("FAIL a5_end got tx/busy/rdy %b want 101", {tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]});
    end
`ifdef HAMMING_TX_PARITY_EN
    checks++;
    if (tx_log[13*CPB + 1] !== 1'b0) begin
      errors++; $display("FAIL a5_parity got %b want 0", tx_log[13*CPB + 1]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int nr;
    in_data = 8'hFF; in_valid = 1'b1;
    capture(FLEN + 1, 1'b1, 8'h00, -1, 8'h00);
    nr = 0;
    for (int i = 0; i < FLEN; i++) begin
      nr += int'(rdy_log[i]);
      checks++;
      if (tx_log[i] !== exp_bit(12'hF77, 1'b0, i / CPB)) begin
        errors++;
        $display("FAIL b2b_ff_tx cycle %0d got %b want %b", i, tx_log[i], exp_bit(12'hF77, 1'b0, i / CPB));
      end
    end
    checks++; if (nr != 0) begin errors++; $display("FAIL b2b_ready_in_frame got %0d cycles want 0", nr); end
    checks++;
    if ({tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_gap got tx/busy/rdy %b want 101", {tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]});
    end
    capture(FLEN + 1, 1'b0, 8'h00, -1, 8'h00);
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (tx_log[i] !== exp_bit(12'h000, 1'b0, i / CPB) || busy_log[i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_00 cycle %0d got tx %b busy %b want tx %b busy 1",
                 i, tx_log[i], busy_log[i], exp_bit(12'h000, 1'b0, i / CPB));
      end
    end
    checks++;
    if ({tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_end got tx/busy/rdy %b want 101", {tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]});
    end
  endtask

  task automatic test_ignore_mid_frame();
    int nb;
    in_data = 8'hA5; in_valid = 1'b1;
    capture(FLEN + 1, 1'b0, 8'h00, 20, 8'h5A);
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (tx_log[i] !== exp_bit(12'hA27, 1'b0, i / CPB)) begin
        errors++;
        $display("FAIL ignore_tx cycle %0d got %b want %b", i, tx_log[i], exp_bit(12'hA27, 1'b0, i / CPB));
      end
    end
    capture(2 * FLEN, 1'b0, 8'h00, -1, 8'h00);
    nb = 0;
    for (int i = 0; i < 2 * FLEN; i++) nb += int'(busy_log[i]) + int'(!tx_log[i]);
    checks++; if (nb != 0) begin errors++; $display("FAIL ignore_second_frame got %0d active samples want 0", nb); end
  endtask

  task automatic test_reset_mid_frame();
    in_data = 8'hA5; in_valid = 1'b1;
    capture(7 * CPB + 2, 1'b0, 8'h00, -1, 8'h00);
    checks++;
    if ({tx_log[7*CPB + 1], busy_log[7*CPB + 1]} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_bit6 got tx/busy %b want 01", {tx_log[7*CPB + 1], busy_log[7*CPB + 1]});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx, busy, in_ready} !== 3'b100) begin
      errors++; $display("FAIL rstmid_async got tx/busy/rdy %b want 100", {tx, busy, in_ready});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_data = 8'h3C; in_valid = 1'b1;
    capture(FLEN + 1, 1'b0, 8'h00, -1, 8'h00);
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (tx_log[i] !== exp_bit(12'h362, 1'b1, i / CPB) || busy_log[i] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_3c cycle %0d got tx %b busy %b want tx %b busy 1",
                 i, tx_log[i], busy_log[i], exp_bit(12'h362, 1'b1, i / CPB));
      end
    end
    checks++;
    if ({tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]} !== 3'b101) begin
      errors++;
      $display("FAIL rstmid_end got tx/busy/rdy %b want 101", {tx_log[FLEN], busy_log[FLEN], rdy_log[FLEN]});
    end
  endtask

`ifdef HAMMING_TX_PARITY_EN
  task automatic test_parity();
    int nb;
    in_data = 8'h01; in_valid = 1'b1;
    capture(FLEN + 1, 1'b0, 8'h00, -1, 8'h00);
    for (int i = 0; i < FLEN; i++) begin
      checks++;
      if (tx_log[i] !== exp_bit(12'h007, 1'b1, i / CPB)) begin
        errors++;
        $display("FAIL par01_tx cycle %0d got %b want %b", i, tx_log[i], exp_bit(12'h007, 1'b1, i / CPB));
      end
    end
    checks++;
    if (tx_log[13*CPB + 2] !== 1'b1) begin
      errors++; $display("FAIL par01_parity got %b want 1", tx_log[13*CPB + 2]);
    end
    nb = 0;
    for (int i = 0; i <= FLEN; i++) nb += int'(busy_log[i]);
    checks++; if (nb != 60) begin errors++; $display("FAIL par01_len got %0d want 60", nb); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_a5();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_ignore_mid_frame();
    @(negedge clk);
    test_reset_mid_frame();
`ifdef HAMMING_TX_PARITY_EN
    @(negedge clk);
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
